// File: rtl/sample_sequencer.sv
// ============================================================================
// Module   : sample_sequencer
// Purpose  : Run controller for the AZ sample acquisition block. It applies a
//            holdoff, arms acquisition and counts ADC measurements. Defining
//            SAMPLE_SEQ_TIMEOUT_EN adds an armed-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_sequencer #(
    parameter int CNT_W = 24
`ifdef SAMPLE_SEQ_TIMEOUT_EN
    ,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TIMEOUT_N = CLK_FREQ * 1
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] sample_n,
    input  logic [CNT_W-1:0] holdoff_n,
    input  logic             adc_measure_valid,
    output logic             arm_trigger,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLDOFF = 2'd1,
        S_ARMED   = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_sample_n;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_arm;
    logic             r_done;
    logic             r_gap_cnt;
    logic             r_valid_prev;

    logic             w_edge;
    logic [CNT_W-1:0] w_count_inc;

`ifdef SAMPLE_SEQ_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_N + 1);
    logic [c_WD_W-1:0] r_wd;
    logic              r_timeout;
`endif

    assign w_edge      = adc_measure_valid & ~r_valid_prev;
    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sample_n   <= '0;
            r_hold_cnt   <= '0;
            r_count      <= '0;
            r_arm        <= 1'b0;
            r_done       <= 1'b0;
            r_gap_cnt    <= 1'b0;
            r_valid_prev <= 1'b0;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
            r_wd         <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_valid_prev <= adc_measure_valid;
            case (r_state)
                S_IDLE: begin
                    // A simultaneous abort cancels the request outright
                    if (start && !abort) begin
                        r_sample_n <= sample_n;
                        r_count    <= '0;
                        r_done     <= 1'b0;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
                        r_timeout  <= 1'b0;
                        r_wd       <= c_WD_W'(TIMEOUT_N);
`endif
                        if (holdoff_n == '0) begin
                            r_state <= S_ARMED;
                            r_arm   <= 1'b1;
                        end else begin
                            r_state    <= S_HOLDOFF;
                            r_hold_cnt <= holdoff_n;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (abort) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= 1'b0;
                    end else if (r_hold_cnt == CNT_W'(1)) begin
                        r_state <= S_ARMED;
                        r_arm   <= 1'b1;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
                        r_wd    <= c_WD_W'(TIMEOUT_N);
`endif
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_ARMED: begin
                    if (abort) begin
                        r_arm     <= 1'b0;
                        r_state   <= S_GAP;
                        r_gap_cnt <= 1'b0;
                    end else if (w_edge) begin
                        r_count <= w_count_inc;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
                        r_wd    <= c_WD_W'(TIMEOUT_N);
`endif
                        if (r_sample_n != '0 && w_count_inc == r_sample_n) begin
                            r_arm     <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_GAP;
                            r_gap_cnt <= 1'b0;
                        end
                    end
`ifdef SAMPLE_SEQ_TIMEOUT_EN
                    else if (r_wd == '0) begin
                        r_arm     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_GAP;
                        r_gap_cnt <= 1'b0;
                    end else begin
                        r_wd <= r_wd - 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    // Two low cycles let the downstream edge detector see the fall
                    if (r_gap_cnt) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_arm   <= 1'b0;
                end
            endcase
        end
    end

    assign arm_trigger  = r_arm;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign sample_count = r_count;

`ifdef SAMPLE_SEQ_TIMEOUT_EN
    assign timeout_err = r_timeout;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_sequencer.sv
// ============================================================================
// Module   : tb_sample_sequencer
// Purpose  : Self-checking bench for sample_sequencer; counts are tracked by a
//            scoreboard queue filled when valid pulses are driven.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_sequencer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] sample_n;
    logic [CNT_W-1:0] holdoff_n;
    logic             adc_measure_valid;
    logic             arm_trigger;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    int exp_q[$];

    sample_sequencer #(
        .CNT_W(CNT_W)
`ifdef SAMPLE_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_N(100)
`endif
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .sample_n         (sample_n),
        .holdoff_n        (holdoff_n),
        .adc_measure_valid(adc_measure_valid),
        .arm_trigger      (arm_trigger),
        .busy             (busy),
        .done             (done),
        .sample_count     (sample_count),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every nonzero change of sample_count must match the next expected value
    logic [CNT_W-1:0] prev_count = '0;
    always @(negedge clk) begin
        if (sample_count !== prev_count) begin
            if (sample_count != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL count_unexpected actual=%0d required=none", sample_count);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (sample_count !== CNT_W'(e)) begin
                        errors++;
                        $display("FAIL count_seq actual=%0d required=%0d", sample_count, e);
                    end
                end
            end
            prev_count = sample_count;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int len, input int gap, input bit counted);
        if (counted) begin
            model_count++;
            exp_q.push_back(model_count);
        end
        adc_measure_valid = 1'b1;
        repeat (len) cyc();
        adc_measure_valid = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic begin_run(input int n, input int h);
        sample_n    = CNT_W'(n);
        holdoff_n   = CNT_W'(h);
        start       = 1'b1;
        cyc();
        start       = 1'b0;
        model_count = 0;
    endtask

    task automatic wait_arm(input int limit);
        int k;
        k = 0;
        while (arm_trigger !== 1'b1 && k < limit) begin
            cyc();
            k++;
        end
        checks++;
        if (arm_trigger !== 1'b1) begin
            errors++;
            $display("FAIL wait_arm actual=%b required=1 after %0d cycles", arm_trigger, limit);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        checks++;
        if ({arm_trigger, busy, done, timeout_err} !== 4'b0000 || sample_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b%b%b%b/%0d required=0000/0",
                     arm_trigger, busy, done, timeout_err, sample_count);
        end
    endtask

    task automatic test_counted_run();
        begin_run(3, 10);
        checks++;
        if (busy !== 1'b1 || arm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_busy actual=busy%b arm%b required=busy1 arm0", busy, arm_trigger);
        end
        repeat (9) cyc();
        checks++;
        if (arm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL arm_early actual=%b required=0 at t+10", arm_trigger);
        end
        cyc();
        checks++;
        if (arm_trigger !== 1'b1) begin
            errors++;
            $display("FAIL arm_t11 actual=%b required=1 at t+11", arm_trigger);
        end
        pulse(1, 2, 1'b1);
        pulse(2, 2, 1'b1);
        pulse(1, 0, 1'b1);
        checks++;
        if (arm_trigger !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL final_sample actual=arm%b done%b busy%b required=arm0 done1 busy1",
                     arm_trigger, done, busy);
        end
        cyc();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_busy actual=%b required=1", busy);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || sample_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL run_end actual=busy%b done%b cnt%0d required=busy0 done1 cnt3",
                     busy, done, sample_count);
        end
    endtask

    task automatic test_free_run();
        begin_run(0, 2);
        checks++;
        if (done !== 1'b0 || sample_count !== '0) begin
            errors++;
            $display("FAIL start_clears actual=done%b cnt%0d required=done0 cnt0", done, sample_count);
        end
        wait_arm(10);
        pulse(1, 1, 1'b1);
        pulse(4, 2, 1'b1);
        pulse(1, 3, 1'b1);
        pulse(2, 1, 1'b1);
        pulse(1, 1, 1'b1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (arm_trigger !== 1'b0 || done !== 1'b0 || sample_count !== CNT_W'(5)) begin
            errors++;
            $display("FAIL free_abort actual=arm%b done%b cnt%0d required=arm0 done0 cnt5",
                     arm_trigger, done, sample_count);
        end
        repeat (2) cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL free_idle actual=%b required=0", busy);
        end
    endtask

    task automatic test_start_while_busy();
        begin_run(5, 0);
        checks++;
        if (arm_trigger !== 1'b1) begin
            errors++;
            $display("FAIL holdoff0_arm actual=%b required=1", arm_trigger);
        end
        pulse(1, 1, 1'b1);
        pulse(1, 1, 1'b1);
        sample_n  = CNT_W'(1);
        holdoff_n = CNT_W'(7);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        checks++;
        if (sample_count !== CNT_W'(2) || arm_trigger !== 1'b1) begin
            errors++;
            $display("FAIL busy_start actual=cnt%0d arm%b required=cnt2 arm1", sample_count, arm_trigger);
        end
        pulse(3, 1, 1'b1);
        checks++;
        if (done !== 1'b0 || arm_trigger !== 1'b1 || sample_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL no_relatch actual=done%b arm%b cnt%0d required=done0 arm1 cnt3",
                     done, arm_trigger, sample_count);
        end
        adc_measure_valid = 1'b1;
        abort             = 1'b1;
        cyc();
        adc_measure_valid = 1'b0;
        abort             = 1'b0;
        checks++;
        if (sample_count !== CNT_W'(3) || arm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL abort_edge actual=cnt%0d arm%b required=cnt3 arm0", sample_count, arm_trigger);
        end
        repeat (2) cyc();
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || arm_trigger !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort_start actual=busy%b arm%b required=busy0 arm0", busy, arm_trigger);
        end
    endtask

    task automatic test_reset_mid_armed();
        begin_run(0, 0);
        pulse(1, 1, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if ({arm_trigger, busy, done, timeout_err} !== 4'b0000 || sample_count !== '0) begin
            errors++;
            $display("FAIL reset_mid actual=%b%b%b%b/%0d required=0000/0",
                     arm_trigger, busy, done, timeout_err, sample_count);
        end
        begin_run(0, 0);
        checks++;
        if (arm_trigger !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm_after_reset actual=arm%b busy%b required=arm1 busy1", arm_trigger, busy);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_timeout();
        begin_run(0, 0);
`ifdef SAMPLE_SEQ_TIMEOUT_EN
        repeat (100) cyc();
        checks++;
        if (arm_trigger !== 1'b1) begin
            errors++;
            $display("FAIL wd_early actual=%b required=1 at arm+100", arm_trigger);
        end
        cyc();
        checks++;
        if (arm_trigger !== 1'b0 || timeout_err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL wd_fire actual=arm%b to%b done%b required=arm0 to1 done0",
                     arm_trigger, timeout_err, done);
        end
        repeat (2) cyc();
`else
        repeat (150) cyc();
        checks++;
        if (arm_trigger !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL no_wd actual=arm%b to%b required=arm1 to0", arm_trigger, timeout_err);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        repeat (2) cyc();
`endif
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        abort             = 1'b0;
        sample_n          = '0;
        holdoff_n         = '0;
        adc_measure_valid = 1'b0;
        test_reset();
        test_counted_run();
        test_free_run();
        test_start_while_busy();
        test_reset_mid_armed();
        test_timeout();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
